// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: handshake and data bundle around the pipelined decode stage.
//   flush                       kill the instruction held in the ID/EX register
//   in_valid/in_ready/in_instr  fetch -> decode handshake
//   wb_en/wb_rd/wb_data         register-file write-back port
//   out_valid/out_ready         decode -> execute handshake
//   out_*                       registered decode results
// Modports: slave = decode stage, master = surrounding pipeline / bench.
interface decode_stage_pipe_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTRUCTION = 32,
  parameter int unsigned ALU_CONTROL = 4
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTRUCTION-1:0] in_instr;
  logic                   wb_en;
  logic [4:0]             wb_rd;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [ALU_CONTROL-1:0] out_alu_control;
  logic [DATA_WIDTH-1:0]  out_opa;
  logic [DATA_WIDTH-1:0]  out_opb;
  logic [DATA_WIDTH-1:0]  out_store_data;
  logic [4:0]             out_rd;
  logic                   out_reg_write;
  logic                   out_load;
  logic                   out_store;
  logic                   out_mem_en;
  logic [1:0]             out_mem_to_reg;
  logic                   out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_alu_control, out_opa, out_opb, out_store_data, out_rd,
           out_reg_write, out_load, out_store, out_mem_en, out_mem_to_reg, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_alu_control, out_opa, out_opb, out_store_data, out_rd,
           out_reg_write, out_load, out_store, out_mem_en, out_mem_to_reg, out_illegal
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: pipelined RV32I decode stage (R/I/L/S/LUI) with an internal register
// file, registered ID/EX outputs, load-use stall, flush and illegal-opcode flagging.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  decode_stage_pipe_if.slave (fetch handshake, write-back port, ID/EX outputs)
// Optional macro DECODE_WB_BYPASS_EN: same-cycle write-back is forwarded to the register
// read (write-first). Without it the read returns the old register value.
module decode_stage_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTRUCTION = 32,
  parameter int unsigned ALU_CONTROL = 4,
  parameter int unsigned NUM_REGS    = 32
) (
  input logic                 clk,
  input logic                 rst,
  decode_stage_pipe_if.slave  bus
);
  localparam int unsigned IDX_W   = $clog2(NUM_REGS);
  localparam bit          FULL_RF = (NUM_REGS == 32);

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                         ALU_SLT = 4'b0011, ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_OR = 4'b1000,
                         ALU_AND = 4'b1001;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_LUI = 7'b0110111;

  // Register file
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [4:0]            rs1, rs2;
  logic                  rs1_ok, rs2_ok, wb_ok;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  // Index 0 and indices beyond the implemented registers read as zero and are never written.
  assign rs1_ok = (rs1 != 5'd0) && (FULL_RF || ({1'b0, rs1} < 6'(NUM_REGS)));
  assign rs2_ok = (rs2 != 5'd0) && (FULL_RF || ({1'b0, rs2} < 6'(NUM_REGS)));
  assign wb_ok  = bus.wb_en && (bus.wb_rd != 5'd0) &&
                  (FULL_RF || ({1'b0, bus.wb_rd} < 6'(NUM_REGS)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[bus.wb_rd[IDX_W-1:0]] <= bus.wb_data;
    end
  end

  always_comb begin
    rs1_val = rs1_ok ? regs[rs1[IDX_W-1:0]] : '0;
    rs2_val = rs2_ok ? regs[rs2[IDX_W-1:0]] : '0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_ok && rs1_ok && (bus.wb_rd == rs1)) rs1_val = bus.wb_data;
    if (wb_ok && rs2_ok && (bus.wb_rd == rs2)) rs2_val = bus.wb_data;
`endif
  end

  // Immediates: size-cast of a signed value sign-extends to DATA_WIDTH.
  logic signed [11:0]    imm_i12, imm_s12;
  logic signed [31:0]    imm_u32;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_u;

  assign imm_i12 = bus.in_instr[31:20];
  assign imm_s12 = {bus.in_instr[31:25], bus.in_instr[11:7]};
  assign imm_u32 = {bus.in_instr[31:12], 12'b0};
  assign imm_i   = DATA_WIDTH'(imm_i12);
  assign imm_s   = DATA_WIDTH'(imm_s12);
  assign imm_u   = DATA_WIDTH'(imm_u32);

  // Decode
  logic [6:0]            opcode;
  logic [2:0]            fun3;
  logic                  bit30;
  logic [3:0]            dec_alu;
  logic [DATA_WIDTH-1:0] dec_opa, dec_opb;
  logic                  dec_rw, dec_load, dec_store, dec_mem_en, dec_illegal;
  logic [1:0]            dec_m2r;
  logic                  rs1_used, rs2_used;

  assign opcode = bus.in_instr[6:0];
  assign fun3   = bus.in_instr[14:12];
  assign bit30  = bus.in_instr[30];

  always_comb begin
    dec_alu     = ALU_ADD;
    dec_opa     = rs1_val;
    dec_opb     = '0;
    dec_rw      = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_mem_en  = 1'b0;
    dec_m2r     = 2'b00;
    dec_illegal = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        unique case (fun3)
          // Only R-type distinguishes SUB; ADDI has no subtract form.
          3'b000: dec_alu = (opcode == OP_R && bit30) ? ALU_SUB : ALU_ADD;
          3'b001: dec_alu = ALU_SLL;
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b101: dec_alu = bit30 ? ALU_SRA : ALU_SRL;
          3'b110: dec_alu = ALU_OR;
          3'b111: dec_alu = ALU_AND;
        endcase
        dec_opb  = (opcode == OP_R) ? rs2_val : imm_i;
        dec_rw   = 1'b1;
        rs1_used = 1'b1;
        rs2_used = (opcode == OP_R);
      end
      OP_L: begin
        dec_opb    = imm_i;
        dec_load   = 1'b1;
        dec_mem_en = 1'b1;
        dec_m2r    = 2'b01;
        dec_rw     = 1'b1;
        rs1_used   = 1'b1;
      end
      OP_S: begin
        dec_opb    = imm_s;
        dec_store  = 1'b1;
        dec_mem_en = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      OP_LUI: begin
        dec_opa = '0;
        dec_opb = imm_u;
        dec_rw  = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ID/EX register
  logic                  valid_q, rw_q, load_q, store_q, mem_en_q, illegal_q;
  logic [3:0]            alu_q;
  logic [DATA_WIDTH-1:0] opa_q, opb_q, sdata_q;
  logic [4:0]            rd_q;
  logic [1:0]            m2r_q;
  logic                  stall, accept;

  // Load-use: the load in ID/EX has not produced its data yet, so hold the consumer one cycle.
  assign stall  = valid_q && load_q && (rd_q != 5'd0) &&
                  (((rd_q == rs1) && rs1_used) || ((rd_q == rs2) && rs2_used));
  assign bus.in_ready = (!valid_q || bus.out_ready) && !stall && !bus.flush;
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      alu_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      m2r_q     <= '0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      alu_q     <= dec_alu;
      opa_q     <= dec_opa;
      opb_q     <= dec_opb;
      sdata_q   <= rs2_val;
      rd_q      <= bus.in_instr[11:7];
      rw_q      <= dec_rw;
      load_q    <= dec_load;
      store_q   <= dec_store;
      mem_en_q  <= dec_mem_en;
      m2r_q     <= dec_m2r;
      illegal_q <= dec_illegal;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_alu_control = ALU_CONTROL'(alu_q);
  assign bus.out_opa         = opa_q;
  assign bus.out_opb         = opb_q;
  assign bus.out_store_data  = sdata_q;
  assign bus.out_rd          = rd_q;
  assign bus.out_reg_write   = rw_q;
  assign bus.out_load        = load_q;
  assign bus.out_store       = store_q;
  assign bus.out_mem_en      = mem_en_q;
  assign bus.out_mem_to_reg  = m2r_q;
  assign bus.out_illegal     = illegal_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if bus ();

  decode_stage_pipe dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] instr;
    bit          chk_ops;  // data fields are meaningful for this opcode
    bit          chk_rd;
    logic [3:0]  alu;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        st;
    logic        me;
    logic [1:0]  m2r;
    logic        il;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  initial begin
    // x5 = 0x10, x6 = 0xFFFF_FFF0; all other registers 0.
    vecs[0]  = '{32'hFFF28313, 1, 1, 4'h0, 32'h10,       32'hFFFFFFFF, 32'h0,  5'd6,  1, 0, 0, 0, 2'b00, 0};
    vecs[1]  = '{32'h0042A383, 1, 1, 4'h0, 32'h10,       32'h4,        32'h0,  5'd7,  1, 1, 0, 1, 2'b01, 0};
    vecs[2]  = '{32'h40530533, 1, 1, 4'h1, 32'hFFFFFFF0, 32'h10,       32'h10, 5'd10, 1, 0, 0, 0, 2'b00, 0};
    vecs[3]  = '{32'h4032D593, 1, 1, 4'h7, 32'h10,       32'h403,      32'h0,  5'd11, 1, 0, 0, 0, 2'b00, 0};
    vecs[4]  = '{32'hABCDE637, 1, 1, 4'h0, 32'h0,        32'hABCDE000, 32'h0,  5'd12, 1, 0, 0, 0, 2'b00, 0};
    vecs[5]  = '{32'h7FF2C693, 1, 1, 4'h5, 32'h10,       32'h7FF,      32'h0,  5'd13, 1, 0, 0, 0, 2'b00, 0};
    vecs[6]  = '{32'h0062B733, 1, 1, 4'h4, 32'h10, 32'hFFFFFFF0, 32'hFFFFFFF0, 5'd14, 1, 0, 0, 0, 2'b00, 0};
    vecs[7]  = '{32'h0062E7B3, 1, 1, 4'h8, 32'h10, 32'hFFFFFFF0, 32'hFFFFFFF0, 5'd15, 1, 0, 0, 0, 2'b00, 0};
    vecs[8]  = '{32'h0062F0B3, 1, 1, 4'h9, 32'h10, 32'hFFFFFFF0, 32'hFFFFFFF0, 5'd1,  1, 0, 0, 0, 2'b00, 0};
    vecs[9]  = '{32'h0062D133, 1, 1, 4'h6, 32'h10, 32'hFFFFFFF0, 32'hFFFFFFF0, 5'd2,  1, 0, 0, 0, 2'b00, 0};
    vecs[10] = '{32'h0062A1B3, 1, 1, 4'h3, 32'h10, 32'hFFFFFFF0, 32'hFFFFFFF0, 5'd3,  1, 0, 0, 0, 2'b00, 0};
    vecs[11] = '{32'h00629233, 1, 1, 4'h2, 32'h10, 32'hFFFFFFF0, 32'hFFFFFFF0, 5'd4,  1, 0, 0, 0, 2'b00, 0};
    vecs[12] = '{32'h00502423, 1, 0, 4'h0, 32'h0,        32'h8,        32'h10, 5'd0,  0, 0, 1, 1, 2'b00, 0};
    vecs[13] = '{32'hFE532E23, 1, 0, 4'h0, 32'hFFFFFFF0, 32'hFFFFFFFC, 32'h10, 5'd0,  0, 0, 1, 1, 2'b00, 0};
    vecs[14] = '{32'h0000007F, 0, 0, 4'h0, 32'h0,        32'h0,        32'h0,  5'd0,  0, 0, 0, 0, 2'b00, 1};

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_alu", 32'(bus.out_alu_control), 32'h0);
    chk("rst_out_opb", bus.out_opb, 32'h0);
    chk("rst_out_rw", 32'(bus.out_reg_write), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    chk("idle_in_ready", 32'(bus.in_ready), 32'h1);

    wb_write(5'd5, 32'h0000_0010);
    wb_write(5'd6, 32'hFFFF_FFF0);
    wb_write(5'd0, 32'h0000_DEAD);  // x0 must stay 0

    // Table-driven decode, back-to-back at full throughput
    bus.in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.in_instr = vecs[i].instr;
      #3;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'h1);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'h1);
      if (vecs[i].chk_ops) begin
        chk($sformatf("v%0d_alu", i), 32'(bus.out_alu_control), 32'(vecs[i].alu));
        chk($sformatf("v%0d_opa", i), bus.out_opa, vecs[i].opa);
        chk($sformatf("v%0d_opb", i), bus.out_opb, vecs[i].opb);
        chk($sformatf("v%0d_sdata", i), bus.out_store_data, vecs[i].sdata);
      end
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rw", i), 32'(bus.out_reg_write), 32'(vecs[i].rw));
      chk($sformatf("v%0d_load", i), 32'(bus.out_load), 32'(vecs[i].ld));
      chk($sformatf("v%0d_store", i), 32'(bus.out_store), 32'(vecs[i].st));
      chk($sformatf("v%0d_mem_en", i), 32'(bus.out_mem_en), 32'(vecs[i].me));
      chk($sformatf("v%0d_m2r", i), 32'(bus.out_mem_to_reg), 32'(vecs[i].m2r));
      chk($sformatf("v%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].il));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'h0);

    // Load-use: LW x7,4(x5) then ADD x8,x7,x5 -> one bubble
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0042A383;
    tick();
    bus.in_instr = 32'h00538433;
    #1;
    chk("lu_stall_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("lu_bubble_valid", 32'(bus.out_valid), 32'h0);
    chk("lu_after_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("lu_add_valid", 32'(bus.out_valid), 32'h1);
    chk("lu_add_rd", 32'(bus.out_rd), 32'd8);
    chk("lu_add_opb", bus.out_opb, 32'h10);

    // LW then ADD x8,x0,x5 -> no stall
    bus.in_instr = 32'h0042A383;
    tick();
    bus.in_instr = 32'h00500433;
    #1;
    chk("nolu_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("nolu_valid", 32'(bus.out_valid), 32'h1);
    chk("nolu_rd", 32'(bus.out_rd), 32'd8);
    chk("nolu_load", 32'(bus.out_load), 32'h0);

    // Backpressure: ADDI held while out_ready = 0 for 3 cycles
    bus.in_instr = 32'hFFF28313;
    tick();
    bus.out_ready = 1'b0;
    bus.in_instr  = 32'h7FF2C693;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'h0);
      tick();
      chk($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'h1);
      chk($sformatf("bp%0d_rd", c), 32'(bus.out_rd), 32'd6);
      chk($sformatf("bp%0d_opb", c), bus.out_opb, 32'hFFFFFFFF);
      chk($sformatf("bp%0d_alu", c), 32'(bus.out_alu_control), 32'h0);
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();

    // Same-cycle write-back of x9 and read of x9 (ADDI x16, x9, 0)
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00048813;
    bus.wb_en    = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'hAAAA5555;
    tick();
    bus.wb_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    chk("wb_same_cycle_opa", bus.out_opa, 32'hAAAA5555);
`else
    chk("wb_same_cycle_opa", bus.out_opa, 32'h0);
`endif
    tick();
    chk("wb_next_cycle_opa", bus.out_opa, 32'hAAAA5555);

    // Asynchronous reset mid-stream
    bus.in_instr = 32'hFFF28313;
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("async_rst_opb", bus.out_opb, 32'h0);
    chk("async_rst_rd", 32'(bus.out_rd), 32'h0);
    tick();
    rst_n = 1'b1;
    // Register file cleared too: ADD x8,x0,x5 now reads x5 = 0
    bus.in_instr = 32'h00500433;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_x5", bus.out_opb, 32'h0);
    bus.in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Pipelined successor to the combinational decode stage.
- Accepts instructions over a valid/ready handshake and decodes RV32I R/I/L/S/LUI formats.
- Reads an internal register file that has a separate write-back port.
- Registers all decode results into an ID/EX pipeline register. Adds load-use stall, flush and illegal-opcode detection. Sits between fetch and execute.

Parameters:
- DATA_WIDTH, 32, register/operand width; must be >= 32; immediates sign-extended to it.
- INSTRUCTION, 32, instruction width.
- ALU_CONTROL, 4, ALU opcode width.
- NUM_REGS, 32, register count; power of two, <= 32; rs/rd index width is log2(NUM_REGS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- flush  in  1  kill the instruction held in the pipeline register.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  INSTRUCTION  instruction word.
- wb_en  in  1  write-back enable.
- wb_rd  in  5  write-back destination.
- wb_data  in  DATA_WIDTH  write-back data.
- out_valid  out  1  pipeline register holds a valid instruction.
- out_ready  in  1  execute accepts.
- out_alu_control  out  ALU_CONTROL  ALU opcode.
- out_opa  out  DATA_WIDTH  operand A.
- out_opb  out  DATA_WIDTH  operand B (rs2 or immediate).
- out_store_data  out  DATA_WIDTH  rs2 value.
- out_rd  out  5  destination register.
- out_reg_write  out  1  write-back enable for this instruction.
- out_load  out  1  load instruction.
- out_store  out  1  store instruction.
- out_mem_en  out  1  memory access.
- out_mem_to_reg  out  2  write-back source: 00 = ALU, 01 = memory.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (rst low, asynchronous): all out_* = 0, out_valid = 0, all registers = 0. Takes effect mid-operation; no partial state survives.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Writes on the rising edge when wb_en = 1.
  - Read is combinational from in_instr[19:15] / [24:20].
  - Indices >= NUM_REGS read 0 and are not written.
- Immediates: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; U = {instr[31:12], 12'b0}. All sign-extended to DATA_WIDTH.
- ALU encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
  - R-type selects by fun3/fun7[5].
  - I-ALU selects by fun3; SRAI when fun3 = 101 and instr[30] = 1.
  - Load, store and LUI use ADD.
- Decode:
  - R (0110011): opb = rs2, reg_write = 1.
  - I-ALU (0010011): opb = I, reg_write = 1.
  - Load (0000011): opb = I, load = 1, mem_en = 1, mem_to_reg = 01, reg_write = 1.
  - Store (0100011): opb = S, store = 1, mem_en = 1, reg_write = 0.
  - LUI (0110111): opa = 0, opb = U, reg_write = 1.
  - Any other opcode: illegal = 1; reg_write, mem_en, load, store = 0; still handshaken through.
- Hazard: stall = out_valid & out_load & (out_rd != 0) & ((out_rd == rs1 & rs1 used) | (out_rd == rs2 & rs2 used)).
  - rs1 is used by R, I, L, S.
  - rs2 is used by R, S.
- in_ready = (!out_valid | out_ready) & !stall & !flush.
- Pipeline register update, evaluated in priority order:
  - flush → out_valid <= 0.
  - else in_valid & in_ready → load decoded fields, out_valid <= 1.
  - else out_ready → out_valid <= 0 (covers the stall bubble).
  - else hold all out_* unchanged.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 per cycle when there is no stall.
- Load-use inserts exactly one bubble; the dependent instruction is accepted the following cycle.
- Simultaneous wb_en and a read of the same register: see Optional Feature.
- Simultaneous flush and in_valid: the input is not accepted (in_ready = 0).

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: when wb_en = 1, wb_rd != 0 and wb_rd matches rs1/rs2, the read returns wb_data in the same cycle (write-first).
- Undefined: the read returns the old register value. Software or upstream must avoid the same-cycle read-after-write.

Test Plan:
- Reset, then wb x5 = 0x0000_0010; send ADDI x6, x5, -1 (0xFFF28313) → next cycle out_valid = 1, opa = 0x10, opb = 0xFFFF_FFFF, alu = 0000, rd = 6, reg_write = 1.
- LW x7, 4(x5) followed by ADD x8, x7, x5 with out_ready = 1 → in_ready = 0 for one cycle, one bubble (out_valid = 0), then ADD issued. No stall if the second instruction is ADD x8, x0, x5.
- SW x5, 8(x0) (0x00502423) → opb = 8, store_data = 0x10, store = 1, mem_en = 1, reg_write = 0.
- out_ready = 0 for 3 cycles with in_valid = 1 → out_* stable, in_ready = 0. flush asserted → out_valid = 0 next cycle.
- Opcode 0x7F → out_illegal = 1, reg_write = 0. Writing wb_rd = 0 with 0xDEAD → x0 still reads 0.
- wb x9 = 0xAAAA_5555 in the same cycle as a read of x9 → opa = 0xAAAA_5555 with DECODE_WB_BYPASS_EN defined, old value (0) without it. Assert rst mid-stream → out_valid = 0 immediately.
